riscv_run_sequencer: RTL
========================

# riscv_run_sequencer

Parametrised reset-and-run sequencer for the RISC-V simulation and bring-up environment. Holds N core reset channels low for a programmed number of cycles after system reset. Releases the channels synchronously in staggered order, then counts run cycles until every core reports halt or a run budget expires. Sits between the system `clk`/`rst` and the `rst` inputs of one or more `riscv_top` instances, and replaces hand-timed reset/finish delays with a cycle-exact, restartable controller.

## Interface
- `NUM_CH`, 2: number of core reset channels (≥1).
- `HOLD_CYCLES`, 15: cycles all channels are held in reset after `rst` deasserts (≥1).
- `STAGGER`, 4: cycles between successive channel releases (0 = release all together).
- `RUN_CYCLES`, 90: run budget in cycles; must be < 2^`CNT_W`.
- `CNT_W`, 16: width of the cycle counters.

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: restart request; honoured only in DONE/TIMEOUT.
- `halt` in `NUM_CH`: per-core halt indication, level.
- `ch_rst_n` out `NUM_CH`: per-core active-low reset; reset value all 0.
- `running` out 1: high in RUN; reset 0.
- `done` out 1: all cores halted; reset 0.
- `timeout` out 1: run budget expired; reset 0.
- `cycle_count` out `CNT_W`: run cycles elapsed; reset 0.

## Operation
- FSM states: HOLD (reset state), RELEASE, RUN, DONE, TIMEOUT.
- HOLD:
  - `hold_cnt` increments each edge.
  - On the edge where `hold_cnt == HOLD_CYCLES-1`, go to RELEASE with `rel_cnt=0`.
- RELEASE:
  - On each edge, `ch_rst_n[i]` is set to 1 when `rel_cnt == i*STAGGER`; `rel_cnt` increments.
  - On the edge releasing channel `NUM_CH-1`, go to RUN; `cycle_count` is cleared on that edge.
- RUN:
  - `cycle_count` increments each edge.
  - Sticky `halt_seen[i]` is set when `halt[i]=1`. `halt` is ignored for channels still in reset and outside RUN.
  - On the edge where `halt_seen | halt` becomes all ones, go to DONE.
  - Otherwise, on the edge where `cycle_count == RUN_CYCLES-1`, go to TIMEOUT.
  - If both occur on the same edge, DONE wins.
- DONE/TIMEOUT:
  - `cycle_count` is frozen.
  - `ch_rst_n` stays high, so cores keep running/halted.
  - `start=1` returns to HOLD on the next edge: all `ch_rst_n` go to 0, `halt_seen`, `done`, `timeout` and `hold_cnt` are cleared, and the full sequence repeats.
- `start` is ignored in HOLD, RELEASE and RUN.
- `rst` low in any state asynchronously forces all outputs to their reset values, including `ch_rst_n` = 0 immediately, and the FSM enters HOLD.
- Counters never wrap: each is bounded by its terminal compare.

## Timing
- All outputs are registered. Only reset assertion is asynchronous; release is always synchronous to `clk`.
- Edges are numbered from 1, counting the first rising edge after `rst` deasserts.
  - `ch_rst_n[i]` rises on edge `HOLD_CYCLES+1+i*STAGGER`.
  - `running` rises on edge `HOLD_CYCLES+1+(NUM_CH-1)*STAGGER`.
- `done` and `timeout` rise on the same edge as the state transition; `running` falls on that edge.
- `cycle_count` counts edges spent in RUN, including the exit edge:
  - at TIMEOUT it equals `RUN_CYCLES`;
  - at DONE it equals the number of RUN edges up to and including the last halt sample.
- From a `start` edge, `ch_rst_n` is all 0 on the next edge, and release latency matches power-on.

## Configuration
- `RUN_TIMEOUT_EN` defined: the budget compare and TIMEOUT state are present, as described above.
- `RUN_TIMEOUT_EN` undefined:
  - the compare and TIMEOUT state are removed, and `timeout` is tied 0;
  - RUN exits only via DONE;
  - `cycle_count` saturates at 2^`CNT_W`-1 instead of wrapping.

## Structure
- Package `riscv_sim_pkg`:
  - FSM state enum typedef `run_state_t`;
  - default constants for `HOLD_CYCLES`, `STAGGER`, `RUN_CYCLES`, `CNT_W`.
- Sub-module `rst_release_ff`: one per channel (generate loop). It is a single flop with async clear on `rst` and synchronous set on a release strobe from the FSM.

## Test plan
- Power-on with defaults, `rst` low for 15 cycles then high → `ch_rst_n[0]` rises on edge 16 and `ch_rst_n[1]` on edge 20; `running=1` on edge 20.
- `halt[0]` on RUN edge 10, `halt[1]` on RUN edge 30 → `done=1` on edge 30, `cycle_count=30`, `timeout=0`, `running=0`.
- No halt ever, `RUN_TIMEOUT_EN` defined → `timeout=1` with `cycle_count=90`, `done=0`.
- Last halt arrives on RUN edge 90 → `done=1` and `timeout=0`.
- `rst` pulsed low on RUN edge 40 → `ch_rst_n=0` and all outputs reset without waiting for `clk`; after `rst` rises, the release edges again fall on 16 and 20.
- `start` pulse while in RUN is ignored. `start` pulse in DONE → `ch_rst_n=00` and `done=0` next edge, then release on relative edges 16 and 20.

Source files
------------

// File: rtl/riscv_sim_pkg.sv
// Shared definitions for the RISC-V bring-up run sequencer: FSM state encoding
// and default timing constants.
package riscv_sim_pkg;

  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    RELEASE = 3'd1,
    RUN     = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } run_state_t;

  localparam int NUM_CH_DEF      = 2;
  localparam int HOLD_CYCLES_DEF = 15;
  localparam int STAGGER_DEF     = 4;
  localparam int RUN_CYCLES_DEF  = 90;
  localparam int CNT_W_DEF       = 16;

endpackage

// File: rtl/rst_release_ff.sv
// One core reset channel: cleared asynchronously by rst (active low) or
// synchronously by clr, set synchronously by the release strobe.
module rst_release_ff (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic set,
  output logic q
);

  logic q_r;

  // Channel reset state; clear takes priority over set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= 1'b0;
    end else if (clr) begin
      q_r <= 1'b0;
    end else if (set) begin
      q_r <= 1'b1;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/riscv_run_sequencer.sv
// Reset-and-run sequencer: holds core resets, releases them staggered, then
// counts run cycles until all cores halt. Optional feature macro: RUN_TIMEOUT_EN.
module riscv_run_sequencer
  import riscv_sim_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int STAGGER     = STAGGER_DEF,
  parameter int RUN_CYCLES  = RUN_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] halt,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'((NUM_CH - 1) * STAGGER);
`ifdef RUN_TIMEOUT_EN
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);
`else
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
`endif

  run_state_t        state_r;
  run_state_t        state_nxt_s;
  logic [CNT_W-1:0]  hold_cnt_r;
  logic [CNT_W-1:0]  rel_cnt_r;
  logic [CNT_W-1:0]  cycle_count_r;
  logic [NUM_CH-1:0] halt_seen_r;
  logic [NUM_CH-1:0] halt_live_s;
  logic [NUM_CH-1:0] rel_set_s;
  logic              all_halted_s;
  logic              start_acc_s;
  logic              running_r;
  logic              done_r;

  // A core still held in reset cannot report a meaningful halt.
  assign halt_live_s  = halt & ch_rst_n;
  assign all_halted_s = (state_r == RUN) &&
                        ((halt_seen_r | halt_live_s) == {NUM_CH{1'b1}});
  assign start_acc_s  = start && ((state_r == DONE) || (state_r == TIMEOUT));

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= HOLD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; halting beats the budget when both hit on one edge.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      HOLD: begin
        if (hold_cnt_r == HOLD_LAST) begin
          state_nxt_s = RELEASE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      RELEASE: begin
        if (rel_cnt_r == REL_LAST) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = RELEASE;
        end
      end
      RUN: begin
        if (all_halted_s) begin
          state_nxt_s = DONE;
`ifdef RUN_TIMEOUT_EN
        end else if (cycle_count_r == RUN_LAST) begin
          state_nxt_s = TIMEOUT;
`endif
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = DONE;
        end
      end
`ifdef RUN_TIMEOUT_EN
      TIMEOUT: begin
        if (start) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = TIMEOUT;
        end
      end
`endif
      default: begin
        state_nxt_s = HOLD;
      end
    endcase
  end

  // Hold and release counters; both stop at their terminal value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt_r <= '0;
      rel_cnt_r  <= '0;
    end else if (start_acc_s) begin
      hold_cnt_r <= '0;
      rel_cnt_r  <= '0;
    end else begin
      case (state_r)
        HOLD: begin
          rel_cnt_r <= '0;
          if (hold_cnt_r != HOLD_LAST) begin
            hold_cnt_r <= hold_cnt_r + CNT_ONE;
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        RELEASE: begin
          hold_cnt_r <= hold_cnt_r;
          if (rel_cnt_r != REL_LAST) begin
            rel_cnt_r <= rel_cnt_r + CNT_ONE;
          end else begin
            rel_cnt_r <= rel_cnt_r;
          end
        end
        default: begin
          hold_cnt_r <= hold_cnt_r;
          rel_cnt_r  <= rel_cnt_r;
        end
      endcase
    end
  end

  // Run cycle counter: cleared on RUN entry, frozen after RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count_r <= '0;
    end else begin
      case (state_r)
        RELEASE: begin
          if (state_nxt_s == RUN) begin
            cycle_count_r <= '0;
          end else begin
            cycle_count_r <= cycle_count_r;
          end
        end
        RUN: begin
`ifdef RUN_TIMEOUT_EN
          cycle_count_r <= cycle_count_r + CNT_ONE;
`else
          if (cycle_count_r != CNT_MAX) begin
            cycle_count_r <= cycle_count_r + CNT_ONE;
          end else begin
            cycle_count_r <= cycle_count_r;
          end
`endif
        end
        default: begin
          cycle_count_r <= cycle_count_r;
        end
      endcase
    end
  end

  // Sticky per-core halt capture, only meaningful while running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt_seen_r <= '0;
    end else if (start_acc_s) begin
      halt_seen_r <= '0;
    end else if (state_r == RUN) begin
      halt_seen_r <= halt_seen_r | halt_live_s;
    end else begin
      halt_seen_r <= halt_seen_r;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CNT_W-1:0] REL_AT = CNT_W'(i * STAGGER);
    assign rel_set_s[i] = (state_r == RELEASE) && (rel_cnt_r == REL_AT);
    rst_release_ff u_release (
      .clk (clk),
      .rst (rst),
      .clr (start_acc_s),
      .set (rel_set_s[i]),
      .q   (ch_rst_n[i])
    );
  end

  // Status flags follow the state being entered, so they move with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      running_r <= (state_nxt_s == RUN);
      done_r    <= (state_nxt_s == DONE);
    end
  end

`ifdef RUN_TIMEOUT_EN
  logic timeout_r;

  // Budget-expired flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= (state_nxt_s == TIMEOUT);
    end
  end

  assign timeout = timeout_r;
`else
  assign timeout = 1'b0;
`endif

  assign running     = running_r;
  assign done        = done_r;
  assign cycle_count = cycle_count_r;

endmodule
